// File: rtl/cam_gray_stream.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cam_gray_stream
// Front end of the edge-detection path. Captures an 8-bit DVP bus carrying
// RGB565 (two bytes per pixel, high byte first) and converts each pixel to an
// 8-bit luma value. Produces one dout_vld beat per forwarded pixel, with
// dout_sop on pixel (0,0) and dout_eop on pixel (IMG_W-1, IMG_H-1).
// No backpressure; clk is the camera PCLK.
//
// Ports
//   clk        in   pixel clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   capture enable, looked at only when a frame starts
//   cam_vsync  in   frame sync, rising edge starts a frame
//   cam_href   in   line valid
//   cam_data   in   [7:0] DVP byte
//   dout       out  [7:0] luma, holds its value between beats
//   dout_sop   out  first pixel of frame (qualified by dout_vld)
//   dout_eop   out  last pixel of frame (qualified by dout_vld)
//   dout_vld   out  pixel strobe
//   frame_done out  one-cycle pulse on the eop beat
//   frame_err  out  one-cycle pulse when a frame is cut short by vsync
// -----------------------------------------------------------------------------
module cam_gray_stream #(
    parameter int         IMG_W       = 640,
    parameter int         IMG_H       = 480,
    parameter logic [7:0] SKIP_FRAMES = 8'd10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_data,
    output logic [7:0] dout,
    output logic       dout_sop,
    output logic       dout_eop,
    output logic       dout_vld,
    output logic       frame_done,
    output logic       frame_err
);

    // Counters run one past the last index so surplus pixels can be detected
    // and dropped without wrapping.
    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);

    localparam logic [CW-1:0] COL_END  = CW'(IMG_W);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_END  = RW'(IMG_H);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [7:0]    SKIP_LAST = SKIP_FRAMES - 8'd1;

    typedef enum logic [1:0] {
        S_SKIP,
        S_WAIT_VS,
        S_CAP
    } state_t;

    // ---------------- stage 0: input registers ----------------
    logic       r_vsync, r_vsync_d;
    logic       r_href, r_href_d;
    logic [7:0] r_data;

    logic w_vs_rise;
    logic w_href_fall;

    // NOTE: clocked state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync   <= 1'b0;
            r_vsync_d <= 1'b0;
            r_href    <= 1'b0;
            r_href_d  <= 1'b0;
            r_data    <= 8'd0;
        end else begin
            r_vsync   <= cam_vsync;
            r_vsync_d <= r_vsync;
            r_href    <= cam_href;
            r_href_d  <= r_href;
            r_data    <= cam_data;
        end
    end

    assign w_vs_rise   = r_vsync & ~r_vsync_d;
    assign w_href_fall = r_href_d & ~r_href;

    // ---------------- byte phase / pixel assembly ----------------
    // r_phase=1 means r_hi holds the first byte and r_data is the second.
    logic       r_phase;
    logic [7:0] r_hi;
    logic       w_pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 1'b0;
            r_hi    <= 8'd0;
        end else if (r_href) begin
            if (!r_phase) r_hi <= r_data;
            r_phase <= ~r_phase;
        end else begin
            // A dangling first byte at the end of a line is thrown away here.
            r_phase <= 1'b0;
        end
    end

    assign w_pix = r_href & r_phase;

    // ---------------- FSM and counters ----------------
    state_t        r_state, w_state_nxt;
    logic [7:0]    r_skip_cnt;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    logic w_cap_pix;
    logic w_fwd;
    logic w_sop;
    logic w_eop;
    logic w_frame_err;

    assign w_cap_pix = w_pix && (r_state == S_CAP);
    assign w_fwd     = w_cap_pix && (r_col < COL_END) && (r_row < ROW_END);
    assign w_sop     = (r_col == '0) && (r_row == '0);
    assign w_eop     = (r_col == COL_LAST) && (r_row == ROW_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_SKIP;
        else        r_state <= w_state_nxt;
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_frame_err = 1'b0;
        case (r_state)
            S_SKIP: begin
                if (SKIP_FRAMES == 8'd0)
                    w_state_nxt = S_WAIT_VS;
                else if (w_vs_rise && (r_skip_cnt == SKIP_LAST))
                    w_state_nxt = S_WAIT_VS;
            end
            S_WAIT_VS: begin
                if (w_vs_rise && en) w_state_nxt = S_CAP;
            end
            S_CAP: begin
                if (w_vs_rise) begin
                    // New frame started before the old one reached eop.
                    w_frame_err = 1'b1;
                    w_state_nxt = en ? S_CAP : S_WAIT_VS;
                end else if (w_fwd && w_eop) begin
                    w_state_nxt = S_WAIT_VS;
                end
            end
            default: w_state_nxt = S_SKIP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skip_cnt <= 8'd0;
        end else if ((r_state == S_SKIP) && w_vs_rise) begin
            r_skip_cnt <= r_skip_cnt + 8'd1;
        end
    end

    // Every frame start clears the position; outside CAP the counters idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_vs_rise) begin
            r_col <= '0;
            r_row <= '0;
        end else if (r_state == S_CAP) begin
            if (w_cap_pix) begin
                if (r_col != COL_END) r_col <= r_col + CW'(1);
            end else if (w_href_fall && (r_col != '0)) begin
                r_col <= '0;
                if (r_row != ROW_END) r_row <= r_row + RW'(1);
            end
        end
    end

    // ---------------- stage 1: assembled pixel ----------------
    logic [15:0] r_s1_pix;
    logic        r_s1_vld, r_s1_sop, r_s1_eop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_pix <= 16'd0;
            r_s1_vld <= 1'b0;
            r_s1_sop <= 1'b0;
            r_s1_eop <= 1'b0;
        end else begin
            if (w_fwd) r_s1_pix <= {r_hi, r_data};
            r_s1_vld <= w_fwd;
            r_s1_sop <= w_fwd & w_sop;
            r_s1_eop <= w_fwd & w_eop;
        end
    end

    // ---------------- stage 2: weighted channels ----------------
    // Channels widened to 8 bits by replicating their MSBs into the LSBs.
    logic [7:0]  w_r8, w_g8, w_b8;
    logic [15:0] r_p_r, r_p_g, r_p_b;
    logic        r_s2_vld, r_s2_sop, r_s2_eop;

    assign w_r8 = {r_s1_pix[15:11], r_s1_pix[15:13]};
    assign w_g8 = {r_s1_pix[10:5],  r_s1_pix[10:9]};
    assign w_b8 = {r_s1_pix[4:0],   r_s1_pix[4:2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_r    <= 16'd0;
            r_p_g    <= 16'd0;
            r_p_b    <= 16'd0;
            r_s2_vld <= 1'b0;
            r_s2_sop <= 1'b0;
            r_s2_eop <= 1'b0;
        end else begin
            r_p_r    <= 16'd77  * {8'd0, w_r8};
            r_p_g    <= 16'd150 * {8'd0, w_g8};
            r_p_b    <= 16'd29  * {8'd0, w_b8};
            r_s2_vld <= r_s1_vld;
            r_s2_sop <= r_s1_sop;
            r_s2_eop <= r_s1_eop;
        end
    end

    // ---------------- stage 3: luma and outputs ----------------
    // Weights sum to 256, so the 16-bit sum cannot overflow (max 65280).
    logic [15:0] w_sum;
    logic [7:0]  r_dout;
    logic        r_vld, r_sop, r_eop, r_frame_err;

    assign w_sum = r_p_r + r_p_g + r_p_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout      <= 8'd0;
            r_vld       <= 1'b0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (r_s2_vld) r_dout <= w_sum[15:8];
            r_vld       <= r_s2_vld;
            r_sop       <= r_s2_sop;
            r_eop       <= r_s2_eop;
            r_frame_err <= w_frame_err;
        end
    end

    assign dout       = r_dout;
    assign dout_vld   = r_vld;
    assign dout_sop   = r_sop;
    assign dout_eop   = r_eop;
    assign frame_done = r_eop;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_cam_gray_stream.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_cam_gray_stream
// Drives DVP frames into cam_gray_stream (4x2 image, 2 settle frames) and
// compares every output beat against a queue of expected pixels, including
// the cycle on which each beat must appear.
// -----------------------------------------------------------------------------
module tb_cam_gray_stream;

    localparam int         W    = 4;
    localparam int         H    = 2;
    localparam logic [7:0] SKIP = 8'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       cam_vsync = 1'b0;
    logic       cam_href = 1'b0;
    logic [7:0] cam_data = 8'd0;
    logic [7:0] dout;
    logic       dout_sop, dout_eop, dout_vld, frame_done, frame_err;

    cam_gray_stream #(
        .IMG_W      (W),
        .IMG_H      (H),
        .SKIP_FRAMES(SKIP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .dout      (dout),
        .dout_sop  (dout_sop),
        .dout_eop  (dout_eop),
        .dout_vld  (dout_vld),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] y;
        logic       sop;
        logic       eop;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         vld_seen = 0;
    int         done_seen = 0;
    int         err_seen = 0;
    logic [7:0] last_y = 8'd0;
    logic [15:0] line_buf [0:7];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference luma: expand each channel to 8 bits, weight, keep the top byte.
    function automatic logic [7:0] luma(input logic [15:0] px);
        int r, g, b;
        r = int'(px[15:11]); r = (r << 3) | (r >> 2);
        g = int'(px[10:5]);  g = (g << 2) | (g >> 4);
        b = int'(px[4:0]);   b = (b << 3) | (b >> 2);
        return 8'((77 * r + 150 * g + 29 * b) >> 8);
    endfunction

    // Output monitor: every beat is popped from the scoreboard and compared.
    exp_t m_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) err_seen++;
            if (frame_done) done_seen++;
            if (dout_vld) begin
                vld_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat dout=%0d sop=%0b eop=%0b at cyc %0d",
                             dout, dout_sop, dout_eop, cyc);
                end else begin
                    m_e = exp_q.pop_front();
                    if ({dout, dout_sop, dout_eop, frame_done} !== {m_e.y, m_e.sop, m_e.eop, m_e.eop}) begin
                        errors++;
                        $display("FAIL beat got y=%0d sop=%0b eop=%0b done=%0b want y=%0d sop=%0b eop=%0b done=%0b",
                                 dout, dout_sop, dout_eop, frame_done, m_e.y, m_e.sop, m_e.eop, m_e.eop);
                    end
                    checks++;
                    if (cyc !== m_e.cyc) begin
                        errors++;
                        $display("FAIL latency got cyc %0d want cyc %0d", cyc, m_e.cyc);
                    end
                end
            end else begin
                checks++;
                if ({dout_sop, dout_eop, frame_done} !== 3'b000) begin
                    errors++;
                    $display("FAIL stray_flags got sop=%0b eop=%0b done=%0b want 000 at cyc %0d",
                             dout_sop, dout_eop, frame_done, cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vsync_pulse();
        @(negedge clk) cam_vsync = 1'b1;
        repeat (2) @(negedge clk);
        cam_vsync = 1'b0;
        idle(2);
    endtask

    task automatic fill_line(input int kind, input int line);
        for (int p = 0; p < 8; p++) begin
            case (kind)
                0:       line_buf[p] = 16'hFFFF;
                1:       line_buf[p] = (line == 0) ?
                                       ((p == 0) ? 16'hF800 : (p == 1) ? 16'h07E0 :
                                        (p == 2) ? 16'h001F : 16'h0000) :
                                       16'(16'h1234 * (p + 1));
                default: line_buf[p] = 16'($urandom);
            endcase
        end
    endtask

    // Sends n pixels on one href; expectations pushed for pixels the DUT must forward.
    task automatic send_line(input int n, input bit odd, input int line,
                             input bit cap, input int drop_en_at);
        for (int p = 0; p < n; p++) begin
            @(negedge clk);
            cam_href = 1'b1;
            cam_data = line_buf[p][15:8];
            if (p == drop_en_at) en = 1'b0;
            @(negedge clk);
            cam_data = line_buf[p][7:0];
            if (cap && p < W && line < H) begin
                exp_t e;
                e.y   = luma(line_buf[p]);
                e.sop = (p == 0) && (line == 0);
                e.eop = (p == W - 1) && (line == H - 1);
                e.cyc = cyc + 4;
                exp_q.push_back(e);
                last_y = e.y;
            end
        end
        if (odd) begin
            @(negedge clk);
            cam_data = 8'hA5;
        end
        @(negedge clk);
        cam_href = 1'b0;
        cam_data = 8'd0;
        idle(3);
    endtask

    task automatic frame(input int kind, input bit cap, input int n, input bit odd);
        vsync_pulse();
        for (int l = 0; l < H; l++) begin
            fill_line(kind, l);
            send_line(n, odd, l, cap, -1);
        end
        idle(2);
    endtask

    task automatic drain_check(input string name);
        idle(8);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending got %0d beats outstanding want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic delta_check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        checks++;
        if ({dout, dout_sop, dout_eop, dout_vld, frame_done, frame_err} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got %0h want 0",
                     {dout, dout_sop, dout_eop, dout_vld, frame_done, frame_err});
        end
        rst_n = 1'b1;
        idle(3);
        checks++;
        if ({dout, dout_vld, frame_err} !== 10'd0) begin
            errors++;
            $display("FAIL post_reset_idle got %0h want 0", {dout, dout_vld, frame_err});
        end
    endtask

    task automatic test_skip_white();
        int v0, d0;
        v0 = vld_seen;
        frame(0, 1'b0, 4, 1'b0);
        frame(0, 1'b0, 4, 1'b0);
        delta_check("skip_frames_vld", vld_seen - v0, 0);
        v0 = vld_seen;
        d0 = done_seen;
        frame(0, 1'b1, 4, 1'b0);
        drain_check("white_frame");
        delta_check("white_vld", vld_seen - v0, 8);
        delta_check("white_done", done_seen - d0, 1);
    endtask

    task automatic test_colours();
        int v0;
        v0 = vld_seen;
        frame(1, 1'b1, 4, 1'b0);
        drain_check("colour_frame");
        delta_check("colour_vld", vld_seen - v0, 8);
    endtask

    task automatic test_short_frame();
        int e0, d0;
        e0 = err_seen;
        d0 = done_seen;
        vsync_pulse();
        fill_line(2, 0);
        send_line(4, 1'b0, 0, 1'b1, -1);
        frame(2, 1'b1, 4, 1'b0);
        drain_check("short_frame");
        delta_check("short_frame_err", err_seen - e0, 1);
        delta_check("short_frame_done", done_seen - d0, 1);
    endtask

    task automatic test_extra_pixels();
        int v0, d0;
        v0 = vld_seen;
        d0 = done_seen;
        frame(2, 1'b1, 6, 1'b1);
        drain_check("extra_pixels");
        delta_check("extra_vld", vld_seen - v0, 8);
        delta_check("extra_done", done_seen - d0, 1);
    endtask

    task automatic test_en_drop();
        int v0, d0;
        d0 = done_seen;
        vsync_pulse();
        fill_line(2, 0);
        send_line(4, 1'b0, 0, 1'b1, 3);
        fill_line(2, 1);
        send_line(4, 1'b0, 1, 1'b1, -1);
        drain_check("en_drop_frame");
        delta_check("en_drop_done", done_seen - d0, 1);
        v0 = vld_seen;
        frame(2, 1'b0, 4, 1'b0);
        delta_check("en_low_vld", vld_seen - v0, 0);
        en = 1'b1;
        v0 = vld_seen;
        frame(0, 1'b1, 4, 1'b0);
        drain_check("en_resume");
        delta_check("en_resume_vld", vld_seen - v0, 8);
        checks++;
        if (dout !== last_y) begin
            errors++;
            $display("FAIL dout_hold got %0d want %0d", dout, last_y);
        end
    endtask

    task automatic test_reset_midline();
        int v0;
        vsync_pulse();
        fill_line(2, 0);
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            cam_href = 1'b1;
            cam_data = line_buf[p][15:8];
            @(negedge clk);
            cam_data = line_buf[p][7:0];
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dout, dout_sop, dout_eop, dout_vld, frame_done, frame_err} !== 13'd0) begin
            errors++;
            $display("FAIL midline_reset got %0h want 0",
                     {dout, dout_sop, dout_eop, dout_vld, frame_done, frame_err});
        end
        cam_href = 1'b0;
        cam_data = 8'd0;
        idle(3);
        rst_n = 1'b1;
        idle(3);
        v0 = vld_seen;
        frame(2, 1'b0, 4, 1'b0);
        frame(2, 1'b0, 4, 1'b0);
        delta_check("reskip_vld", vld_seen - v0, 0);
        v0 = vld_seen;
        frame(2, 1'b1, 4, 1'b0);
        drain_check("after_reset_frame");
        delta_check("after_reset_vld", vld_seen - v0, 8);
    endtask

    initial begin
        test_reset();
        test_skip_white();
        test_colours();
        test_short_frame();
        test_extra_pixels();
        test_en_drop();
        test_reset_midline();
        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
